// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared types and helpers for the byte-enable SRAM (sram_bw).
//   state_t : clear sequencer states (CLEAR, READY)
//   nlanes  : number of write lanes for a data/lane width pair
//   merge   : lane-wise merge of new data into an old word under a lane mask,
//             shared by the array write path and the read bypass path
// ---------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic {CLEAR, READY} state_t;

  // merge() works on a fixed maximum width; callers zero-extend into it and
  // truncate the result back to their own word width.
  localparam int MAX_DW = 256;
  localparam int MAX_NL = 256;

  function automatic int nlanes(input int dw, input int bw);
    return dw / bw;
  endfunction

  function automatic logic [MAX_DW-1:0] merge(input logic [MAX_DW-1:0] old_word,
                                              input logic [MAX_DW-1:0] new_word,
                                              input logic [MAX_NL-1:0] be,
                                              input int                bw);
    logic [MAX_DW-1:0] lane_ones;
    logic [MAX_DW-1:0] mask;
    lane_ones = (MAX_DW'(1) << bw) - MAX_DW'(1);
    mask      = '0;
    for (int k = 0; k < MAX_NL; k++) begin
      if (be[k]) mask |= lane_ones << (k * bw);
    end
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// ---------------------------------------------------------------------------
// sram_clear_fsm
// Sequencer that zeroes the whole array after reset, one word per cycle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr_we    : request to write zero at clr_addr this cycle
//   clr_addr  : address being cleared
//   busy_o    : clear in progress; user requests must be ignored
// ---------------------------------------------------------------------------
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int AWIDTH         = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [AWIDTH-1:0] clr_addr,
  output logic              busy_o
);

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] cnt, cnt_nxt;

  // A reset always restarts the clear from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Leave CLEAR on the cycle after the last address has been written, so
  // the sequence lasts exactly 2**AWIDTH cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    busy_o    = 1'b0;
    case (state)
      CLEAR: begin
        busy_o  = 1'b1;
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = READY;
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/sram_bw.sv
// ---------------------------------------------------------------------------
// sram_bw
// Simple dual-port SRAM (one write port, one read port, one clock) with
// per-lane byte enables, registered read with valid strobe, configurable
// read-during-write bypass and an optional hardware clear after reset.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   we, be, addr_w,
//   data_i          : write request, lane enables, address, data
//   re, addr_r      : read request and address
//   data_o, valid_o : registered read data and its one-cycle strobe
//   busy_o          : clear sequence running; all requests ignored
// ---------------------------------------------------------------------------
module sram_bw
  import sram_pkg::*;
#(
  parameter  int DWIDTH         = 24,
  parameter  int AWIDTH         = 6,
  parameter  int BWIDTH         = 8,
  parameter  int BYPASS         = 1,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int NLANES         = nlanes(DWIDTH, BWIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [NLANES-1:0] be,
  input  logic [AWIDTH-1:0] addr_w,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              re,
  input  logic [AWIDTH-1:0] addr_r,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic              busy_o
);

  localparam int DEPTH = 2 ** AWIDTH;

  generate
    if (DWIDTH % BWIDTH != 0) begin : g_bad_lanes
      $fatal(1, "sram_bw: DWIDTH must be a multiple of BWIDTH");
    end
    if (DWIDTH > MAX_DW || NLANES > MAX_NL) begin : g_too_wide
      $fatal(1, "sram_bw: DWIDTH exceeds sram_pkg::MAX_DW");
    end
  endgenerate

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              clr_we;
  logic [AWIDTH-1:0] clr_addr;

  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic [NLANES-1:0] wr_be;
  logic [DWIDTH-1:0] wr_word;
  logic [DWIDTH-1:0] rd_word;

  sram_clear_fsm #(
    .AWIDTH         (AWIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy_o   (busy_o)
  );

  // While clearing, the sequencer owns the write port and writes full zero
  // words; otherwise the user port drives it. Nothing is written during rst.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr_w;
    wr_data = data_i;
    wr_be   = be;
    if (busy_o) begin
      wr_en   = clr_we & ~rst;
      wr_addr = clr_addr;
      wr_data = '0;
      wr_be   = '1;
    end else begin
      wr_en   = we & (|be) & ~rst;
    end
    wr_word = DWIDTH'(merge(MAX_DW'(mem[wr_addr]), MAX_DW'(wr_data),
                            MAX_NL'(wr_be), BWIDTH));
  end

  // Same-address read-during-write sees the merged word only with BYPASS;
  // otherwise the array value before the edge is returned.
  always_comb begin
    rd_word = mem[addr_r];
    if ((BYPASS != 0) && we && (addr_w == addr_r)) begin
      rd_word = DWIDTH'(merge(MAX_DW'(mem[addr_r]), MAX_DW'(data_i),
                              MAX_NL'(be), BWIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  // data_o only updates on an accepted read, so it holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (busy_o) begin
      valid_o <= 1'b0;
    end else begin
      valid_o <= re;
      if (re) data_o <= rd_word;
    end
  end

endmodule

// File: tb/tb_sram_bw.sv
// ---------------------------------------------------------------------------
// tb_sram_bw
// Self-checking bench for sram_bw. Two instances share all inputs: one with
// BYPASS=1 and one with BYPASS=0, both clearing on reset. A reference model
// (plain array plus a clear countdown) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_sram_bw;

  localparam int DW    = 24;
  localparam int AW    = 6;
  localparam int BW    = 8;
  localparam int NL    = 3;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic          re;
  logic [NL-1:0] be;
  logic [AW-1:0] addr_w;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] data_i;

  logic [DW-1:0] data_b, data_n;
  logic          valid_b, valid_n;
  logic          busy_b, busy_n;

  logic [DW-1:0] ref_mem [DEPTH];
  int            clear_left;
  logic [DW-1:0] exp_b, exp_n;
  logic          exp_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_bw #(.DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW), .BYPASS(1), .CLEAR_ON_RESET(1)) dut_byp (
    .clk(clk), .rst(rst), .we(we), .be(be), .addr_w(addr_w), .data_i(data_i),
    .re(re), .addr_r(addr_r), .data_o(data_b), .valid_o(valid_b), .busy_o(busy_b)
  );

  sram_bw #(.DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW), .BYPASS(0), .CLEAR_ON_RESET(1)) dut_old (
    .clk(clk), .rst(rst), .we(we), .be(be), .addr_w(addr_w), .data_i(data_i),
    .re(re), .addr_r(addr_r), .data_o(data_n), .valid_o(valid_n), .busy_o(busy_n)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] laneWrite(input logic [DW-1:0] old_word,
                                             input logic [DW-1:0] d,
                                             input logic [NL-1:0] b);
    logic [DW-1:0] w;
    w = old_word;
    for (int k = 0; k < NL; k++) begin
      if (b[k]) w[k*BW +: BW] = d[k*BW +: BW];
    end
    return w;
  endfunction

  // Drive one cycle of inputs, advance the model, clock, then check outputs.
  task automatic applyStimulus(input logic r, input logic w, input logic [NL-1:0] b,
                               input logic [AW-1:0] aw, input logic [DW-1:0] d,
                               input logic rd, input logic [AW-1:0] ar);
    rst = r; we = w; be = b; addr_w = aw; data_i = d; re = rd; addr_r = ar;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      clear_left = DEPTH;
      exp_b      = '0;
      exp_n      = '0;
      exp_valid  = 1'b0;
    end else if (clear_left > 0) begin
      clear_left--;
      exp_valid = 1'b0;
    end else begin
      exp_valid = rd;
      if (rd) begin
        exp_n = ref_mem[ar];
        exp_b = (w && aw == ar) ? laneWrite(ref_mem[ar], d, b) : ref_mem[ar];
      end
      if (w) ref_mem[aw] = laneWrite(ref_mem[aw], d, b);
    end
    @(posedge clk);
    #1;
    checkOutput("busy_byp",  32'(busy_b),  32'(clear_left > 0));
    checkOutput("busy_old",  32'(busy_n),  32'(clear_left > 0));
    checkOutput("valid_byp", 32'(valid_b), 32'(exp_valid));
    checkOutput("valid_old", 32'(valid_n), 32'(exp_valid));
    checkOutput("data_byp",  32'(data_b),  32'(exp_b));
    checkOutput("data_old",  32'(data_n),  32'(exp_n));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Run through a clear and check its length; optionally poke requests.
  task automatic waitClear(input int expect_len, input logic poke);
    int n;
    n = 0;
    while (busy_b && n < 200) begin
      if (poke && n == 10) applyStimulus(1'b0, 1'b1, 3'b111, 6'd63, 24'hFFFFFF, 1'b1, 6'd63);
      else idle();
      n++;
    end
    checkOutput("clear_len", 32'(n), 32'(expect_len));
  endtask

  task automatic readAllZero();
    for (int a = 0; a < DEPTH; a++) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(a));
    idle();
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset then clear, with a write/read poked in mid-clear.
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    checkOutput("reset_busy", 32'(busy_b), 32'd1);
    waitClear(64, 1'b1);
    readAllZero();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 6'd63);
    checkOutput("gated_addr63", 32'(data_b), 32'h0);

    // Byte enables.
    applyStimulus(1'b0, 1'b1, 3'b111, 6'd5, 24'hAABBCC, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 3'b010, 6'd5, 24'h112233, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 6'd5);
    checkOutput("be_merge", 32'(data_b), 32'hAA22CC);
    applyStimulus(1'b0, 1'b1, 3'b000, 6'd5, 24'hFFFFFF, 1'b1, 6'd5);
    checkOutput("be_zero_noop", 32'(data_n), 32'hAA22CC);

    // Read-during-write, both bypass settings.
    applyStimulus(1'b0, 1'b1, 3'b111, 6'd9, 24'h000001, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 3'b001, 6'd9, 24'h0000FF, 1'b1, 6'd9);
    checkOutput("rdw_bypass", 32'(data_b), 32'h0000FF);
    checkOutput("rdw_old",    32'(data_n), 32'h000001);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 6'd9);

    // Hold/valid behaviour.
    applyStimulus(1'b0, 1'b1, 3'b111, 6'd3, 24'h123456, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 6'd3);
    checkOutput("hold_valid0", 32'(valid_b), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput("hold_valid", 32'(valid_b), 32'd0);
      checkOutput("hold_data",  32'(data_b),  32'h123456);
    end

    // Random traffic on a small address window to force collisions.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), NL'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 7)), DW'($urandom),
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
    end

    // Reset mid-clear restarts from address 0.
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 20; i++) idle();
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    waitClear(64, 1'b0);
    readAllZero();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
